soc_addr_map_unit: RTL and testbench

SOC_ADDR_MAP_UNIT -- requirements
Module: soc_addr_map_unit

---
 rtl/soc_addr_map_pkg.sv | 59 +++++
 rtl/soc_addr_map_match.sv | 27 ++
 rtl/soc_addr_map_unit.sv | 191 +++++++++++++++++++
 tb/tb_soc_addr_map_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_addr_map_pkg.sv
// soc_addr_map_pkg: rule record, config field encoding and the default SoC
// address map shared by the address map unit and its priority matcher.
// Rule storage always uses the maximum widths below; narrower instances
// zero-extend addresses and keep only the low IdxWidth bits of the index.
package soc_addr_map_pkg;

  localparam int unsigned MaxAddrWidth    = 64;
  localparam int unsigned MaxIdxWidth     = 32;
  localparam int unsigned NumDefaultRules = 13;

  typedef struct packed {
    logic [MaxIdxWidth-1:0]  idx;
    logic [MaxAddrWidth-1:0] start_addr;
    logic [MaxAddrWidth-1:0] end_addr;    // exclusive
    logic                    enable;
  } rule_t;

  typedef enum logic [1:0] {
    CfgStart = 2'd0,
    CfgEnd   = 2'd1,
    CfgIdx   = 2'd2,
    CfgCtrl  = 2'd3
  } cfg_field_e;

  typedef rule_t [NumDefaultRules-1:0] rule_map_t;

  function automatic rule_t mk_rule(input logic [MaxIdxWidth-1:0]  idx,
                                    input logic [MaxAddrWidth-1:0] base,
                                    input logic [MaxAddrWidth-1:0] size);
    rule_t r;
    r.idx        = idx;
    r.start_addr = base;
    r.end_addr   = base + size;
    r.enable     = 1'b1;
    return r;
  endfunction

  // Rule number equals slave index in the reset map.
  function automatic rule_map_t build_default_map();
    rule_map_t m;
    m[0]  = mk_rule(32'd0,  64'h0000_0000, 64'h0000_1000); // Debug
    m[1]  = mk_rule(32'd1,  64'h0200_0000, 64'h0004_0000); // BootROM
    m[2]  = mk_rule(32'd2,  64'h0204_0000, 64'h0004_0000); // CLINT
    m[3]  = mk_rule(32'd3,  64'h0208_0000, 64'h0004_0000); // IRQ router
    m[4]  = mk_rule(32'd4,  64'h0400_0000, 64'h0800_0000); // PLIC
    m[5]  = mk_rule(32'd5,  64'h1C00_0000, 64'h0010_0000); // L2SPM
    m[6]  = mk_rule(32'd6,  64'h0300_0000, 64'h0000_1000); // SoC regs
    m[7]  = mk_rule(32'd7,  64'h0300_2000, 64'h0000_1000); // UART
    m[8]  = mk_rule(32'd8,  64'h0300_3000, 64'h0000_1000); // I2C
    m[9]  = mk_rule(32'd9,  64'h0300_4000, 64'h0000_1000); // SPI
    m[10] = mk_rule(32'd10, 64'h0300_5000, 64'h0000_1000); // GPIO
    m[11] = mk_rule(32'd11, 64'h0300_1000, 64'h0000_1000); // LLC cfg
    m[12] = mk_rule(32'd12, 64'h8000_0000, 64'h2000_0000); // HYAXI
    return m;
  endfunction

  localparam rule_map_t DefaultMap = build_default_map();

endpackage

// File: rtl/soc_addr_map_match.sv
// soc_addr_map_match: combinational priority decoder. The lowest-numbered
// enabled rule with start <= addr < end wins; start >= end never matches.
module soc_addr_map_match
  import soc_addr_map_pkg::*;
#(
  parameter int unsigned NumRules = 13
) (
  input  rule_t [NumRules-1:0]     rules_i,
  input  logic  [MaxAddrWidth-1:0] addr_i,
  output logic                     hit_o,
  output logic  [MaxIdxWidth-1:0]  idx_o
);

  // Scan upward and keep the first hit so lower rule numbers take priority
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int unsigned i = 0; i < NumRules; i++) begin
      if (!hit_o && rules_i[i].enable &&
          (addr_i >= rules_i[i].start_addr) && (addr_i < rules_i[i].end_addr)) begin
        hit_o = 1'b1;
        idx_o = rules_i[i].idx;
      end
    end
  end

endmodule

// File: rtl/soc_addr_map_unit.sv
// soc_addr_map_unit: registered address-to-slave-index lookup with a
// programmable rule table, a config port and a saturating miss counter.
// Build option: define SOC_ADDR_MAP_RUNTIME_PROG_EN to make the rule table
// writable at run time; otherwise the table is fixed at DefaultRules, all
// writes are refused and lock_o reads as 1.
module soc_addr_map_unit
  import soc_addr_map_pkg::*;
#(
  parameter int unsigned          NumRules     = 13,
  parameter int unsigned          AddrWidth    = 64,
  parameter int unsigned          IdxWidth     = 32,
  parameter logic [IdxWidth-1:0]  DefaultIdx   = '0,
  parameter rule_t [NumRules-1:0] DefaultRules = DefaultMap
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        lkp_valid_i,
  output logic                        lkp_ready_o,
  input  logic [AddrWidth-1:0]        lkp_addr_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [IdxWidth-1:0]         res_idx_o,
  output logic                        res_decerr_o,
  input  logic                        cfg_req_i,
  input  logic                        cfg_we_i,
  input  logic [$clog2(NumRules)-1:0] cfg_rule_i,
  input  logic [1:0]                  cfg_field_i,
  input  logic [AddrWidth-1:0]        cfg_wdata_i,
  output logic                        cfg_gnt_o,
  output logic                        cfg_rvalid_o,
  output logic [AddrWidth-1:0]        cfg_rdata_o,
  output logic                        cfg_err_o,
  output logic                        lock_o,
  output logic [31:0]                 miss_cnt_o
);

  rule_t [NumRules-1:0]    table_q;
  logic                    lock_q;
  logic                    rule_ok;
  logic                    wr_ok;
  logic [MaxAddrWidth-1:0] lkp_addr_ext;
  logic                    hit;
  logic [MaxIdxWidth-1:0]  hit_idx;
  logic                    lkp_accept;

  logic                    res_valid_q, res_valid_d;
  logic [IdxWidth-1:0]     res_idx_q, res_idx_d;
  logic                    res_decerr_q, res_decerr_d;
  logic [31:0]             miss_cnt_q, miss_cnt_d;

  logic                    cfg_rvalid_q;
  logic                    cfg_err_q, cfg_err_d;
  logic [AddrWidth-1:0]    cfg_rdata_q, cfg_rdata_d;
  logic [AddrWidth-1:0]    rd_data;

  assign rule_ok = (32'(cfg_rule_i) < NumRules);

`ifdef SOC_ADDR_MAP_RUNTIME_PROG_EN
  rule_t [NumRules-1:0] table_d;
  logic                 lock_d;

  // Once locked, every write is refused until the next reset
  assign wr_ok = cfg_req_i & cfg_we_i & rule_ok & ~lock_q;

  // Apply an accepted config write to the addressed rule field
  always_comb begin
    table_d = table_q;
    lock_d  = lock_q;
    if (wr_ok) begin
      case (cfg_field_e'(cfg_field_i))
        CfgStart: table_d[cfg_rule_i].start_addr = MaxAddrWidth'(cfg_wdata_i);
        CfgEnd:   table_d[cfg_rule_i].end_addr   = MaxAddrWidth'(cfg_wdata_i);
        CfgIdx:   table_d[cfg_rule_i].idx        = MaxIdxWidth'(cfg_wdata_i[IdxWidth-1:0]);
        CfgCtrl: begin
          table_d[cfg_rule_i].enable = cfg_wdata_i[0];
          if (cfg_wdata_i[1]) lock_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Rule table and lock; a write takes effect for lookups from the next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      table_q <= DefaultRules;
      lock_q  <= 1'b0;
    end else begin
      table_q <= table_d;
      lock_q  <= lock_d;
    end
  end
`else
  logic unused_cfg_wdata;

  assign table_q          = DefaultRules;
  assign lock_q           = 1'b1;
  assign wr_ok            = 1'b0;
  assign unused_cfg_wdata = ^cfg_wdata_i;
`endif

  assign lkp_addr_ext = MaxAddrWidth'(lkp_addr_i);

  soc_addr_map_match #(
    .NumRules (NumRules)
  ) u_match (
    .rules_i (table_q),
    .addr_i  (lkp_addr_ext),
    .hit_o   (hit),
    .idx_o   (hit_idx)
  );

  // The result slot can take a new lookup when empty or being drained
  assign lkp_ready_o = ~res_valid_q | res_ready_i;
  assign lkp_accept  = lkp_valid_i & lkp_ready_o;

  // Next-state for the result slot and the saturating miss counter
  always_comb begin
    res_valid_d  = res_valid_q;
    res_idx_d    = res_idx_q;
    res_decerr_d = res_decerr_q;
    miss_cnt_d   = miss_cnt_q;
    if (lkp_accept) begin
      res_valid_d  = 1'b1;
      res_idx_d    = hit ? hit_idx[IdxWidth-1:0] : DefaultIdx;
      res_decerr_d = ~hit;
      if (!hit && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
    end else if (res_ready_i) begin
      res_valid_d  = 1'b0;
    end
  end

  // Result slot and miss counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q  <= 1'b0;
      res_idx_q    <= '0;
      res_decerr_q <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      res_valid_q  <= res_valid_d;
      res_idx_q    <= res_idx_d;
      res_decerr_q <= res_decerr_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Config read mux; the control field reports the global lock in bit 1
  always_comb begin
    rd_data = '0;
    if (rule_ok) begin
      case (cfg_field_e'(cfg_field_i))
        CfgStart: rd_data = table_q[cfg_rule_i].start_addr[AddrWidth-1:0];
        CfgEnd:   rd_data = table_q[cfg_rule_i].end_addr[AddrWidth-1:0];
        CfgIdx:   rd_data = AddrWidth'(table_q[cfg_rule_i].idx[IdxWidth-1:0]);
        CfgCtrl:  rd_data = AddrWidth'({lock_q, table_q[cfg_rule_i].enable});
        default:  rd_data = '0;
      endcase
    end
  end

  // Config response contents: errors for bad rule numbers and refused writes
  always_comb begin
    cfg_err_d   = cfg_req_i & (~rule_ok | (cfg_we_i & ~wr_ok));
    cfg_rdata_d = (cfg_req_i & ~cfg_we_i) ? rd_data : '0;
  end

  // Config response registers, one cycle after the grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_rvalid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_rdata_q  <= '0;
    end else begin
      cfg_rvalid_q <= cfg_req_i;
      cfg_err_q    <= cfg_err_d;
      cfg_rdata_q  <= cfg_rdata_d;
    end
  end

  assign res_valid_o  = res_valid_q;
  assign res_idx_o    = res_idx_q;
  assign res_decerr_o = res_decerr_q;
  assign cfg_gnt_o    = cfg_req_i;
  assign cfg_rvalid_o = cfg_rvalid_q;
  assign cfg_rdata_o  = cfg_rdata_q;
  assign cfg_err_o    = cfg_err_q;
  assign lock_o       = lock_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_soc_addr_map_unit.sv
// tb_soc_addr_map_unit: directed and randomized checks of soc_addr_map_unit
// against a rule-list reference model. Follows the DUT build option
// SOC_ADDR_MAP_RUNTIME_PROG_EN when deciding whether writes should succeed.
`timescale 1ns/1ps
module tb_soc_addr_map_unit;

  localparam int N  = 13;
  localparam int AW = 64;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lkp_valid, lkp_ready;
  logic [AW-1:0] lkp_addr;
  logic          res_valid, res_ready, res_decerr;
  logic [IW-1:0] res_idx;
  logic          cfg_req, cfg_we, cfg_gnt, cfg_rvalid, cfg_err;
  logic [3:0]    cfg_rule;
  logic [1:0]    cfg_field;
  logic [AW-1:0] cfg_wdata, cfg_rdata;
  logic          lock;
  logic [31:0]   miss_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  soc_addr_map_unit dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .lkp_valid_i  (lkp_valid),
    .lkp_ready_o  (lkp_ready),
    .lkp_addr_i   (lkp_addr),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_idx_o    (res_idx),
    .res_decerr_o (res_decerr),
    .cfg_req_i    (cfg_req),
    .cfg_we_i     (cfg_we),
    .cfg_rule_i   (cfg_rule),
    .cfg_field_i  (cfg_field),
    .cfg_wdata_i  (cfg_wdata),
    .cfg_gnt_o    (cfg_gnt),
    .cfg_rvalid_o (cfg_rvalid),
    .cfg_rdata_o  (cfg_rdata),
    .cfg_err_o    (cfg_err),
    .lock_o       (lock),
    .miss_cnt_o   (miss_cnt)
  );

  // Reference model: a plain list of rules searched in order
  logic [63:0] m_start [N];
  logic [63:0] m_end   [N];
  logic [31:0] m_idx   [N];
  bit          m_en    [N];
  bit          m_lock;
  logic [31:0] m_miss;

  function automatic void model_reset();
    logic [63:0] st [N] = '{64'h0000_0000, 64'h0200_0000, 64'h0204_0000, 64'h0208_0000,
                            64'h0400_0000, 64'h1C00_0000, 64'h0300_0000, 64'h0300_2000,
                            64'h0300_3000, 64'h0300_4000, 64'h0300_5000, 64'h0300_1000,
                            64'h8000_0000};
    logic [63:0] sz [N] = '{64'h1000, 64'h4_0000, 64'h4_0000, 64'h4_0000,
                            64'h800_0000, 64'h10_0000, 64'h1000, 64'h1000,
                            64'h1000, 64'h1000, 64'h1000, 64'h1000,
                            64'h2000_0000};
    for (int r = 0; r < N; r++) begin
      m_start[r] = st[r];
      m_end[r]   = st[r] + sz[r];
      m_idx[r]   = 32'(r);
      m_en[r]    = 1'b1;
    end
`ifdef SOC_ADDR_MAP_RUNTIME_PROG_EN
    m_lock = 1'b0;
`else
    m_lock = 1'b1;
`endif
    m_miss = 32'd0;
  endfunction

  function automatic void model_lookup(input logic [63:0] a, output logic [31:0] idx, output bit err);
    idx = 32'd0;
    err = 1'b1;
    for (int r = 0; r < N; r++) begin
      if (m_en[r] && (m_start[r] <= a) && (a < m_end[r])) begin
        idx = m_idx[r];
        err = 1'b0;
        return;
      end
    end
  endfunction

  function automatic void model_count_miss(input bit miss);
    if (miss && (m_miss != 32'hFFFF_FFFF)) m_miss = m_miss + 32'd1;
  endfunction

  function automatic void model_cfg(input bit we, input int rule, input logic [1:0] field,
                                    input logic [63:0] wd, output logic [63:0] rd, output bit err);
    rd  = 64'd0;
    err = 1'b0;
    if (rule >= N) begin
      err = 1'b1;
    end else if (we) begin
      if (m_lock) err = 1'b1;
      else begin
        case (field)
          2'd0: m_start[rule] = wd;
          2'd1: m_end[rule]   = wd;
          2'd2: m_idx[rule]   = wd[31:0];
          default: begin
            m_en[rule] = wd[0];
            if (wd[1]) m_lock = 1'b1;
          end
        endcase
      end
    end else begin
      case (field)
        2'd0: rd = m_start[rule];
        2'd1: rd = m_end[rule];
        2'd2: rd = {32'd0, m_idx[rule]};
        default: rd = {62'd0, m_lock, m_en[rule]};
      endcase
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One lookup with the result drained immediately; slot must be empty on entry
  task automatic lookup_once(input logic [63:0] a, input string tag);
    logic [31:0] ei;
    bit ee;
    model_lookup(a, ei, ee);
    lkp_valid = 1'b1;
    lkp_addr  = a;
    res_ready = 1'b1;
    #1;
    chk({tag, "_ready"}, 64'(lkp_ready), 64'd1);
    tick();
    lkp_valid = 1'b0;
    model_count_miss(ee);
    chk({tag, "_valid"}, 64'(res_valid), 64'd1);
    chk({tag, "_idx"}, 64'(res_idx), 64'(ei));
    chk({tag, "_decerr"}, 64'(res_decerr), 64'(ee));
    chk({tag, "_miss"}, 64'(miss_cnt), 64'(m_miss));
    tick();
    chk({tag, "_drained"}, 64'(res_valid), 64'd0);
  endtask

  task automatic cfg_op(input bit we, input int rule, input logic [1:0] field,
                        input logic [63:0] wd, input string tag);
    logic [63:0] erd;
    bit eerr;
    model_cfg(we, rule, field, wd, erd, eerr);
    cfg_req   = 1'b1;
    cfg_we    = we;
    cfg_rule  = 4'(rule);
    cfg_field = field;
    cfg_wdata = wd;
    #1;
    chk({tag, "_gnt"}, 64'(cfg_gnt), 64'd1);
    tick();
    cfg_req = 1'b0;
    cfg_we  = 1'b0;
    chk({tag, "_rvalid"}, 64'(cfg_rvalid), 64'd1);
    chk({tag, "_err"}, 64'(cfg_err), 64'(eerr));
    chk({tag, "_rdata"}, cfg_rdata, erd);
    chk({tag, "_lock"}, 64'(lock), 64'(m_lock));
    tick();
    chk({tag, "_rvalid_low"}, 64'(cfg_rvalid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ei, ni;
    bit ee, ne, ev, eerr, acc;
    logic [31:0] eidx;
    logic [63:0] a, erd;
    int r;

    lkp_valid = 1'b0; lkp_addr = '0; res_ready = 1'b1;
    cfg_req = 1'b0; cfg_we = 1'b0; cfg_rule = '0; cfg_field = '0; cfg_wdata = '0;
    model_reset();
    rst_n = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_idx", 64'(res_idx), 64'd0);
    chk("rst_res_decerr", 64'(res_decerr), 64'd0);
    chk("rst_cfg_rvalid", 64'(cfg_rvalid), 64'd0);
    chk("rst_cfg_rdata", cfg_rdata, 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_miss", 64'(miss_cnt), 64'd0);
    chk("rst_lock", 64'(lock), 64'(m_lock));
    chk("rst_gnt_idle", 64'(cfg_gnt), 64'd0);
    chk("rst_lkp_ready", 64'(lkp_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Default-map hit and miss
    lookup_once(64'h1C00_0100, "l2spm");
    chk("l2spm_idx_const", 64'(ei), 64'(ei));
    lookup_once(64'h7000_0000, "hole");

    // Backpressure: result must hold while a new lookup waits
    lkp_valid = 1'b1; lkp_addr = 64'h0300_2010; res_ready = 1'b0;
    tick();
    lkp_addr = 64'h0000_0000;
    for (int c = 0; c < 3; c++) begin
      chk("bp_ready_low", 64'(lkp_ready), 64'd0);
      chk("bp_valid_hold", 64'(res_valid), 64'd1);
      chk("bp_idx_hold", 64'(res_idx), 64'd7);
      chk("bp_decerr_hold", 64'(res_decerr), 64'd0);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("bp_ready_release", 64'(lkp_ready), 64'd1);
    tick();
    lkp_valid = 1'b0;
    chk("bp_second_valid", 64'(res_valid), 64'd1);
    chk("bp_second_idx", 64'(res_idx), 64'd0);
    chk("bp_second_decerr", 64'(res_decerr), 64'd0);
    tick();
    chk("bp_drained", 64'(res_valid), 64'd0);

    // Randomized lookups around rule boundaries with random backpressure
    ev = 1'b0; eidx = '0; eerr = 1'b0;
    for (int c = 0; c < 250; c++) begin
      r = int'($urandom_range(0, N-1));
      case ($urandom_range(0, 4))
        0: a = m_start[r] - 64'd1;
        1: a = m_start[r];
        2: a = m_end[r] - 64'd1;
        3: a = m_end[r];
        default: a = {32'd0, $urandom()};
      endcase
      lkp_valid = 1'($urandom_range(0, 1));
      lkp_addr  = a;
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_ready", 64'(lkp_ready), 64'(!ev || res_ready));
      acc = lkp_valid && (!ev || res_ready);
      ni = '0; ne = 1'b0;
      if (acc) model_lookup(a, ni, ne);
      tick();
      if (acc) begin
        ev = 1'b1; eidx = ni; eerr = ne;
        model_count_miss(ne);
      end else if (res_ready) begin
        ev = 1'b0;
      end
      chk("rnd_valid", 64'(res_valid), 64'(ev));
      if (ev) begin
        chk("rnd_idx", 64'(res_idx), 64'(eidx));
        chk("rnd_decerr", 64'(res_decerr), 64'(eerr));
      end
      chk("rnd_miss", 64'(miss_cnt), 64'(m_miss));
    end
    lkp_valid = 1'b0; res_ready = 1'b1;
    tick();
    tick();

    // Config reads, out-of-range rule
    cfg_op(1'b0, 5, 2'd0, 64'd0, "rd5_start");
    cfg_op(1'b0, 5, 2'd1, 64'd0, "rd5_end");
    cfg_op(1'b0, 5, 2'd2, 64'd0, "rd5_idx");
    cfg_op(1'b0, 5, 2'd3, 64'd0, "rd5_ctrl");
    cfg_op(1'b0, 13, 2'd0, 64'd0, "rd13");
    cfg_op(1'b1, 13, 2'd0, 64'h1234, "wr13");

    // Overlapping rule 12, lowest rule wins
    cfg_op(1'b1, 12, 2'd0, 64'h1C00_0000, "wr12_start");
    cfg_op(1'b0, 12, 2'd0, 64'd0, "rd12_start");
    lookup_once(64'h1C00_0100, "overlap");

    // Disable rule 5 while a lookup is accepted in the same cycle
    model_lookup(64'h1C00_0100, ei, ee);
    model_cfg(1'b1, 5, 2'd3, 64'd0, erd, eerr);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_rule = 4'd5; cfg_field = 2'd3; cfg_wdata = 64'd0;
    lkp_valid = 1'b1; lkp_addr = 64'h1C00_0100; res_ready = 1'b1;
    tick();
    cfg_req = 1'b0; cfg_we = 1'b0; lkp_valid = 1'b0;
    model_count_miss(ee);
    chk("same_cyc_idx", 64'(res_idx), 64'(ei));
    chk("same_cyc_decerr", 64'(res_decerr), 64'(ee));
    chk("same_cyc_rvalid", 64'(cfg_rvalid), 64'd1);
    chk("same_cyc_err", 64'(cfg_err), 64'(eerr));
    tick();
    lookup_once(64'h1C00_0100, "after_disable");

    // Lock, then a refused write must leave the rule untouched
    cfg_op(1'b1, 3, 2'd3, 64'h3, "lock_wr");
    cfg_op(1'b1, 3, 2'd0, 64'h1234, "locked_wr");
    cfg_op(1'b0, 3, 2'd0, 64'd0, "locked_rd");
    cfg_op(1'b0, 3, 2'd3, 64'd0, "locked_ctrl");

    // Reset with a result and a config response pending
    lkp_valid = 1'b1; lkp_addr = 64'h7000_0000; res_ready = 1'b0;
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_rule = 4'd0; cfg_field = 2'd1;
    tick();
    lkp_valid = 1'b0; cfg_req = 1'b0;
    chk("pre_rst_valid", 64'(res_valid), 64'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_cfg_rvalid", 64'(cfg_rvalid), 64'd0);
    chk("mid_rst_miss", 64'(miss_cnt), 64'd0);
    chk("mid_rst_lock", 64'(lock), 64'(m_lock));
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    tick();
    chk("post_rst_valid", 64'(res_valid), 64'd0);
    cfg_op(1'b0, 12, 2'd0, 64'd0, "post_rst_rd12");
    cfg_op(1'b0, 5, 2'd3, 64'd0, "post_rst_rd5ctrl");
    lookup_once(64'h1C00_0100, "post_rst_l2spm");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
